// File: rtl/ebpf_fetch_prefetcher_if.sv
// Fetch-side bus bundle: CPU control/decode port plus the IM read handshake.
// The prefetcher drives IM requests and the FIFO head, so it takes the master view.
interface ebpf_fetch_prefetcher_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_addr;
  logic        instr_valid;
  logic [63:0] instr_data;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic        align_err;
  logic [63:0] IM_address;
  logic        IM_read_request;
  logic        IM_read_ready;
  logic [63:0] IM_instruction;

  modport master (
    input  fetch_en, redirect_valid, redirect_addr, instr_ready,
           IM_read_ready, IM_instruction,
    output instr_valid, instr_data, instr_pc, align_err,
           IM_address, IM_read_request
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_addr, instr_ready,
           IM_read_ready, IM_instruction,
    input  instr_valid, instr_data, instr_pc, align_err,
           IM_address, IM_read_request
  );
endinterface

// File: rtl/ebpf_fetch_prefetcher.sv
// eBPF instruction prefetcher: one outstanding IM read at a time, results queued
// with their PCs in a small FIFO; a redirect flushes the queue and drops in-flight data.
//   state     | meaning
//   S_IDLE    | nothing outstanding, may issue
//   S_WAIT    | read outstanding, response will be queued
//   S_DISCARD | read outstanding, response will be dropped
module ebpf_fetch_prefetcher #(
  parameter int          DEPTH       = 4,
  parameter int          INSTR_BYTES = 8,
  parameter logic [63:0] START_ADDR  = 64'h0
) (
  input  logic                        aclk,
  input  logic                        areset,
  ebpf_fetch_prefetcher_if.master     bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic [63:0]   r_fetch_pc, r_im_addr;
  logic          r_im_req, r_align_err;
  logic [63:0]   r_mem_data [DEPTH];
  logic [63:0]   r_mem_pc   [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW-1:0] w_rd_nxt;
  logic [PW:0]   r_count;
  logic [63:0]   r_head_data, r_head_pc;
  logic          w_issue, w_push, w_pop, w_flush;

  assign w_flush  = bus.redirect_valid;
  assign w_pop    = bus.instr_ready && (r_count != '0);
  assign w_rd_nxt = r_rd_ptr + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.fetch_en && !bus.redirect_valid && (r_count < C_DEPTH)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.IM_read_ready) begin
          w_push      = !bus.redirect_valid;
          w_state_nxt = S_IDLE;
        end else if (bus.redirect_valid) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.IM_read_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= START_ADDR;
      r_im_addr   <= START_ADDR;
      r_im_req    <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_im_req    <= w_issue;
      r_align_err <= bus.redirect_valid && (bus.redirect_addr[2:0] != 3'b000);
      if (w_issue) r_im_addr <= r_fetch_pc;
      if (w_flush)     r_fetch_pc <= {bus.redirect_addr[63:3], 3'b000};
      else if (w_push) r_fetch_pc <= r_fetch_pc + 64'(INSTR_BYTES);
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.IM_instruction;
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  // Head registers track the next visible entry so they hold their value once empty.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_head_data <= 64'h0;
      r_head_pc   <= 64'h0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop && (r_count > (PW+1)'(1))) begin
        r_head_data <= r_mem_data[w_rd_nxt];
        r_head_pc   <= r_mem_pc[w_rd_nxt];
      end else if (w_push && ((r_count == '0) || (w_pop && (r_count == (PW+1)'(1))))) begin
        r_head_data <= bus.IM_instruction;
        r_head_pc   <= r_fetch_pc;
      end
    end
  end

  assign bus.instr_valid     = (r_count != '0);
  assign bus.instr_data      = r_head_data;
  assign bus.instr_pc        = r_head_pc;
  assign bus.align_err       = r_align_err;
  assign bus.IM_address      = r_im_addr;
  assign bus.IM_read_request = r_im_req;
endmodule

// File: tb/tb_ebpf_fetch_prefetcher.sv
// Bench for ebpf_fetch_prefetcher: directed scenarios then random traffic, every
// cycle compared against a queue-based reference of the fetch/redirect rules.
module tb_ebpf_fetch_prefetcher;
  localparam int          DEPTH = 4;
  localparam logic [63:0] START = 64'h0;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  ebpf_fetch_prefetcher_if bus();

  ebpf_fetch_prefetcher #(.DEPTH(DEPTH), .INSTR_BYTES(8), .START_ADDR(START)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference: queue of {pc, data}; outstanding read 0=none 1=keep 2=drop
  logic [127:0] m_q[$];
  logic [63:0]  m_pc, m_req_addr, m_head_pc, m_head_data;
  logic         m_req, m_align;
  int           m_out;

  // memory responder
  bit          mem_pend;
  logic [63:0] mem_addr;
  int          mem_due, mem_lat, cyc, req_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = START; m_req_addr = START; m_req = 1'b0; m_align = 1'b0; m_out = 0;
    m_head_pc = 64'h0; m_head_data = 64'h0;
  endtask

  function automatic bit mem_fire();
    return mem_pend && (cyc == mem_due);
  endfunction

  task automatic compare_outputs();
    check("im_req",  64'(bus.IM_read_request), 64'(m_req));
    check("im_addr", bus.IM_address, m_req_addr);
    check("valid",   64'(bus.instr_valid), 64'(m_q.size() != 0));
    check("pc",      bus.instr_pc, m_head_pc);
    check("data",    bus.instr_data, m_head_data);
    check("align",   64'(bus.align_err), 64'(m_align));
  endtask

  task automatic step(input bit fe, input bit rdy, input bit rv, input logic [63:0] ra);
    bit          mr;
    logic [63:0] mi;
    int          n0, out0;
    logic [63:0] pc0;
    mr = mem_fire();
    mi = mr ? (mem_addr ^ 64'hA5) : {$urandom, $urandom};
    if (mr) mem_pend = 1'b0;
    bus.fetch_en = fe; bus.instr_ready = rdy; bus.redirect_valid = rv; bus.redirect_addr = ra;
    bus.IM_read_ready = mr; bus.IM_instruction = mi;

    n0 = m_q.size(); out0 = m_out; pc0 = m_pc;
    m_req = 1'b0;
    m_align = rv && (ra[2:0] != 3'b000);
    if (rv) begin
      m_q.delete();
      m_pc = {ra[63:3], 3'b000};
      if (out0 != 0) m_out = mr ? 0 : 2;
    end else begin
      if (rdy && n0 > 0) void'(m_q.pop_front());
      if (mr && out0 == 1) begin
        m_q.push_back({pc0, mi});
        m_pc = pc0 + 64'd8;
      end
      if (mr) m_out = 0;
      if (out0 == 0 && fe && n0 < DEPTH) begin
        m_req = 1'b1; m_req_addr = pc0; m_out = 1;
      end
    end
    if (m_q.size() > 0) {m_head_pc, m_head_data} = m_q[0];

    @(posedge aclk); #1;
    cyc++;
    compare_outputs();
    if (bus.IM_read_request) begin
      mem_pend = 1'b1; mem_addr = bus.IM_address; mem_due = cyc + mem_lat; req_count++;
    end
  endtask

  // async reset check, then release away from the clock edge; a pending response stays stale
  task automatic do_reset();
    areset = 1'b1;
    bus.fetch_en = 1'b0; bus.redirect_valid = 1'b0; bus.instr_ready = 1'b0;
    bus.IM_read_ready = 1'b0;
    #2;
    check("rst_req",   64'(bus.IM_read_request), 64'd0);
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_addr",  bus.IM_address, START);
    check("rst_data",  bus.instr_data, 64'h0);
    check("rst_align", 64'(bus.align_err), 64'd0);
    model_reset();
    @(posedge aclk); #1;
    cyc++;
    areset = 1'b0;
    if (mem_pend && cyc > mem_due) mem_due = cyc;
    req_count = 0;
  endtask

  initial begin
    bit done;
    bus.fetch_en = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_addr = 64'h0;
    bus.instr_ready = 1'b0; bus.IM_read_ready = 1'b0; bus.IM_instruction = 64'h0;
    mem_pend = 1'b0; mem_addr = 64'h0; mem_due = 0; mem_lat = 3; cyc = 0; req_count = 0;
    model_reset();
    #1;
    do_reset();

    // streaming fetch with consumer always ready
    repeat (30) step(1, 1, 0, 64'h0);
    check("stream_reqs_min", 64'(req_count >= 3), 64'd1);

    // consumer stalled: fill exactly DEPTH entries, then one pop frees one request
    do_reset();
    repeat (40) step(1, 0, 0, 64'h0);
    check("full_reqs", 64'(req_count), 64'd4);
    check("full_last_addr", mem_addr, 64'h18);
    step(1, 1, 0, 64'h0);
    repeat (8) step(1, 0, 0, 64'h0);
    check("refill_reqs", 64'(req_count), 64'd5);
    check("refill_addr", mem_addr, 64'h20);

    // redirect while the second request is outstanding
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (req_count == 2) done = 1'b1;
      else step(1, 1, 0, 64'h0);
    end
    check("redir_wait", 64'(done), 64'd1);
    step(1, 1, 1, 64'h100);
    repeat (20) step(1, 1, 0, 64'h0);

    // misaligned redirect landing on the response cycle
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (mem_fire()) begin
        step(1, 1, 1, 64'h203);
        done = 1'b1;
      end else step(1, 1, 0, 64'h0);
    end
    check("coinc_wait", 64'(done), 64'd1);
    check("coinc_align", 64'(bus.align_err), 64'd1);
    repeat (20) step(1, 1, 0, 64'h0);

    // PC wrap at the top of the address space
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (20) step(1, 1, 0, 64'h0);

    // reset while a read is outstanding; its response arrives after release
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1, 1, 0, 64'h0);
      if (mem_pend) done = 1'b1;
    end
    check("rst_mid_wait", 64'(done), 64'd1);
    do_reset();
    repeat (20) step(1, 1, 0, 64'h0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      mem_lat = $urandom_range(1, 5);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
